req_batch_scheduler: RTL and testbench
======================================

Name: req_batch_scheduler

Overview:
- Collects up to four 12-bit memory request addresses into a batch.
- Orders the batch descending through one internal sort_four instance (combinational, sort_two based).
- Issues the ordered requests one at a time over a valid/ready handshake.
- Sits between the request front-end and the command issue stage of the memory controller. A batch closes when it is full, when a timeout expires, or on flush.

Parameters:
- ADDR_W, 12: address width. Fixed at 12 to match sort_four; any other value is a configuration error.
- TIMEOUT, 16: cycles from the first accept of a batch until a partial batch is forced closed. Legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  upstream request valid.
- req_ready  out  1  scheduler can accept a request.
- req_addr  in  12  request address.
- flush  in  1  close the current partial batch now.
- iss_valid  out  1  sorted request available.
- iss_ready  in  1  downstream accepts the issued request.
- iss_addr  out  12  issued address.
- iss_last  out  1  current issue is the final one of its batch.
- busy  out  1  state is SORT or ISSUE.
- batch_count  out  3  valid entries in the current batch, 0..4.

Behaviour:
- State machine:
  - FILL: accept requests.
  - SORT: one cycle; register the sort_four outputs into sorted[0..3].
  - ISSUE: drain sorted entries.
  - Reset state is FILL.
- Reset values:
  - state FILL, slots 0, sorted 0, batch_count 0, wait_cnt 0, issue index 0.
  - iss_valid 0, iss_addr 0, iss_last 0, busy 0.
  - req_ready = (state==FILL) && !rst, so it is 0 while rst is high.
- Reset mid-batch or mid-issue discards all entries. No partial issue continues.
- FILL:
  - req_ready=1.
  - Accept when req_valid && req_ready: write req_addr into slot[batch_count], then batch_count+1.
  - Unused slots hold 12'h000. Padding sorts to the bottom, so issuing only the top batch_count outputs is exact, including real 0 addresses.
- Timeout:
  - wait_cnt clears on the accept that takes batch_count 0->1.
  - wait_cnt increments every later FILL cycle while batch_count>=1.
  - With the first accept in cycle T, SORT is entered in cycle T+TIMEOUT, unless the batch closed earlier.
- FILL->SORT occurs at the edge where any of these holds:
  - the 4th accept happens;
  - the timeout is reached with batch_count>=1;
  - flush=1 with batch_count>=1 after that cycle's accept.
- Close priorities and corner cases:
  - A simultaneous accept and flush/timeout includes the accepted request in the batch.
  - flush with batch_count 0 and no accept is ignored.
  - Several close conditions in the same cycle produce a single transition.
- SORT:
  - req_ready=0, iss_valid=0.
  - sorted[i] <= sort_four.out_i; keep n=batch_count.
  - Next state is ISSUE.
- ISSUE:
  - iss_valid=1, iss_addr=sorted[idx], iss_last=(idx==n-1).
  - iss_addr and iss_last stay stable while iss_ready=0.
  - On iss_valid && iss_ready: idx+1.
  - On the last handshake: go to FILL, clear slots, batch_count and idx.
  - req_ready is 1 in the following cycle.
- Latency: 4th accept in cycle N -> SORT at N+1 -> first iss_valid at N+2.
- Throughput: one issue per cycle while iss_ready=1.
- No request is accepted in SORT or ISSUE.
- Order: descending by address. Equal addresses are both issued, in adjacent positions.
- Outputs are registered or derived from state registers only. There is no combinational path from iss_ready to req_ready.
- busy=1 in SORT and ISSUE.

Test Plan:
1. Full batch: accept 0x123, 0xFFF, 0x001, 0x800 back-to-back; iss_ready=1.
   - Required: SORT in the cycle after the 4th accept; iss_addr = 0xFFF, 0x800, 0x123, 0x001 on 4 consecutive cycles; iss_last only on 0x001; req_ready returns 1 afterwards.
2. Timeout: TIMEOUT=16; single accept 0x055 in cycle 0, then no traffic.
   - Required: SORT in cycle 16; iss_valid in cycle 17 with iss_addr=0x055, iss_last=1; exactly one issue.
3. Flush with zeros: accept 0x000 and 0x3A0, then flush in the cycle after.
   - Required: issues 0x3A0, then 0x000 with iss_last=1; no padding entries issued.
   - Also: flush while empty causes no state change.
4. Backpressure: full batch 0x010, 0x020, 0x030, 0x040; iss_ready held 0 for 5 cycles, then 1.
   - Required: iss_addr holds 0x040 with iss_valid=1 throughout the stall; req_ready=0 during SORT/ISSUE; order 0x040, 0x030, 0x020, 0x010.
5. Simultaneous close: 3 entries, then the 4th accept in the same cycle as flush.
   - Required: a single batch of 4, correctly sorted.
   - Also: timeout reached in the same cycle as an accept includes that entry.
6. Reset mid-ISSUE: assert rst after 2 issues of a 4-entry batch.
   - Required: next cycle iss_valid=0, batch_count=0, busy=0; after rst falls, a new batch issues only its own addresses.

Source files
------------

// File: rtl/req_batch_scheduler.sv
// Batching request scheduler: gathers up to four addresses, sorts them descending,
// and issues them one per handshake. Also holds the sort_two / sort_four helpers.

module sort_two #(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);
  assign o_hi = (i_a >= i_b) ? i_a : i_b;
  assign o_lo = (i_a >= i_b) ? i_b : i_a;
endmodule

module sort_four #(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] i_in0,
  input  logic [W-1:0] i_in1,
  input  logic [W-1:0] i_in2,
  input  logic [W-1:0] i_in3,
  output logic [W-1:0] o_out0,
  output logic [W-1:0] o_out1,
  output logic [W-1:0] o_out2,
  output logic [W-1:0] o_out3
);
  logic [W-1:0] w_h01, w_l01, w_h23, w_l23, w_mid_a, w_mid_b;

  sort_two #(.W(W)) u_s01 (.i_a(i_in0), .i_b(i_in1), .o_hi(w_h01), .o_lo(w_l01));
  sort_two #(.W(W)) u_s23 (.i_a(i_in2), .i_b(i_in3), .o_hi(w_h23), .o_lo(w_l23));
  sort_two #(.W(W)) u_smax (.i_a(w_h01), .i_b(w_h23), .o_hi(o_out0), .o_lo(w_mid_a));
  sort_two #(.W(W)) u_smin (.i_a(w_l01), .i_b(w_l23), .o_hi(w_mid_b), .o_lo(o_out3));
  // Middle pair: loser of the max race against winner of the min race.
  sort_two #(.W(W)) u_smid (.i_a(w_mid_a), .i_b(w_mid_b), .o_hi(o_out1), .o_lo(o_out2));
endmodule

module req_batch_scheduler #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_flush,
  output logic              o_iss_valid,
  input  logic              i_iss_ready,
  output logic [ADDR_W-1:0] o_iss_addr,
  output logic              o_iss_last,
  output logic              o_busy,
  output logic [2:0]        o_batch_count
);
  typedef enum logic [1:0] {StFill, StSort, StIssue} state_e;

  // During cycle T+k after the first accept, wait_cnt holds k-1.
  localparam logic [7:0] TO_LIMIT = (TIMEOUT >= 2) ? 8'(TIMEOUT - 2) : 8'd0;

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_slot   [4];
  logic [ADDR_W-1:0] r_sorted [4];
  logic [ADDR_W-1:0] w_sorted [4];
  logic [2:0]        r_count, r_n, w_count_after;
  logic [7:0]        r_wait_cnt;
  logic [1:0]        r_idx;
  logic              w_accept, w_timeout, w_close, w_fire, w_last;

  sort_four #(.W(ADDR_W)) u_sort (
    .i_in0 (r_slot[0]),
    .i_in1 (r_slot[1]),
    .i_in2 (r_slot[2]),
    .i_in3 (r_slot[3]),
    .o_out0(w_sorted[0]),
    .o_out1(w_sorted[1]),
    .o_out2(w_sorted[2]),
    .o_out3(w_sorted[3])
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StFill;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_accept      = (r_state == StFill) && i_req_valid && !i_rst;
    w_count_after = r_count + {2'b00, w_accept};
    if (TIMEOUT == 1) w_timeout = (w_count_after != 3'd0);
    else              w_timeout = (r_count != 3'd0) && (r_wait_cnt == TO_LIMIT);
    w_close = (r_state == StFill) &&
              ((w_accept && r_count == 3'd3) || w_timeout || (i_flush && w_count_after != 3'd0));
    w_fire  = (r_state == StIssue) && i_iss_ready;
    w_last  = ({1'b0, r_idx} == r_n - 3'd1);

    o_req_ready   = (r_state == StFill) && !i_rst;
    o_iss_valid   = (r_state == StIssue);
    o_iss_addr    = (r_state == StIssue) ? r_sorted[r_idx] : '0;
    o_iss_last    = (r_state == StIssue) && w_last;
    o_busy        = (r_state == StSort) || (r_state == StIssue);
    o_batch_count = r_count;

    unique case (r_state)
      StFill:  if (w_close) w_state_next = StSort;
      StSort:  w_state_next = StIssue;
      StIssue: if (w_fire && w_last) w_state_next = StFill;
      default: w_state_next = StFill;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 4; i++) begin
        r_slot[i]   <= '0;
        r_sorted[i] <= '0;
      end
      r_count    <= 3'd0;
      r_n        <= 3'd0;
      r_wait_cnt <= 8'd0;
      r_idx      <= 2'd0;
    end else begin
      unique case (r_state)
        StFill: begin
          if (w_accept) begin
            r_slot[r_count[1:0]] <= i_req_addr;
            r_count              <= w_count_after;
          end
          if (w_accept && r_count == 3'd0) r_wait_cnt <= 8'd0;
          else if (r_count != 3'd0)        r_wait_cnt <= r_wait_cnt + 8'd1;
        end
        StSort: begin
          for (int i = 0; i < 4; i++) r_sorted[i] <= w_sorted[i];
          r_n <= r_count;
        end
        StIssue: begin
          if (w_fire) begin
            if (w_last) begin
              // Padding must return to zero so it keeps sorting below real entries.
              for (int i = 0; i < 4; i++) r_slot[i] <= '0;
              r_count    <= 3'd0;
              r_wait_cnt <= 8'd0;
              r_idx      <= 2'd0;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_req_batch_scheduler.sv
// Directed bench for req_batch_scheduler: one task per scenario with inline checks.

module tb_req_batch_scheduler;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, flush, iss_valid, iss_ready, iss_last, busy;
  logic [11:0] req_addr, iss_addr;
  logic [2:0]  batch_count;
  int          vectors = 0;
  int          errors  = 0;

  req_batch_scheduler #(.ADDR_W(12), .TIMEOUT(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_addr   (req_addr),
    .i_flush      (flush),
    .o_iss_valid  (iss_valid),
    .i_iss_ready  (iss_ready),
    .o_iss_addr   (iss_addr),
    .o_iss_last   (iss_last),
    .o_busy       (busy),
    .o_batch_count(batch_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0; iss_ready = 1'b1;
    step(); step();
    vectors++;
    if ({req_ready, iss_valid, iss_last, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {req_ready, iss_valid, iss_last, busy});
    end
    vectors++;
    if ({batch_count, iss_addr} !== 15'd0) begin
      errors++; $display("FAIL reset_data: got cnt=%0d addr=%h want 0/000", batch_count, iss_addr);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_full_batch();
    logic [11:0] in_v [4] = '{12'h123, 12'hFFF, 12'h001, 12'h800};
    logic [11:0] exp_v[4] = '{12'hFFF, 12'h800, 12'h123, 12'h001};
    iss_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = in_v[i];
      step();
      vectors++;
      if (batch_count !== 3'(i + 1)) begin
        errors++; $display("FAIL full_count%0d: got %0d want %0d", i, batch_count, i + 1);
      end
    end
    req_valid = 1'b0;
    vectors++;
    if ({busy, iss_valid, req_ready} !== 3'b100) begin
      errors++; $display("FAIL full_sort_state: got %b want 100", {busy, iss_valid, req_ready});
    end
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({iss_valid, iss_addr, iss_last} !== {1'b1, exp_v[i], (i == 3)}) begin
        errors++; $display("FAIL full_issue%0d: got v=%b a=%h l=%b want v=1 a=%h l=%b",
                           i, iss_valid, iss_addr, iss_last, exp_v[i], (i == 3));
      end
      step();
    end
    vectors++;
    if ({req_ready, busy, iss_valid, batch_count} !== {3'b100, 3'd0}) begin
      errors++; $display("FAIL full_done: got rdy=%b busy=%b v=%b cnt=%0d want 1 0 0 0",
                         req_ready, busy, iss_valid, batch_count);
    end
  endtask

  task automatic test_timeout();
    iss_ready = 1'b1;
    req_valid = 1'b1; req_addr = 12'h055;
    step();
    req_valid = 1'b0;
    repeat (14) step();
    vectors++;
    if ({busy, batch_count} !== {1'b0, 3'd1}) begin
      errors++; $display("FAIL timeout_cycle15: got busy=%b cnt=%0d want 0 1", busy, batch_count);
    end
    step();
    vectors++;
    if ({busy, iss_valid} !== 2'b10) begin
      errors++; $display("FAIL timeout_sort16: got busy=%b v=%b want 1 0", busy, iss_valid);
    end
    step();
    vectors++;
    if ({iss_valid, iss_addr, iss_last} !== {1'b1, 12'h055, 1'b1}) begin
      errors++; $display("FAIL timeout_issue17: got v=%b a=%h l=%b want 1 055 1",
                         iss_valid, iss_addr, iss_last);
    end
    step();
    vectors++;
    if ({iss_valid, busy, req_ready} !== 3'b001) begin
      errors++; $display("FAIL timeout_single: got v=%b busy=%b rdy=%b want 0 0 1",
                         iss_valid, busy, req_ready);
    end
  endtask

  task automatic test_flush_zeros();
    iss_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++;
    if ({busy, batch_count, req_ready} !== {1'b0, 3'd0, 1'b1}) begin
      errors++; $display("FAIL flush_empty: got busy=%b cnt=%0d rdy=%b want 0 0 1",
                         busy, batch_count, req_ready);
    end
    req_valid = 1'b1; req_addr = 12'h000; step();
    req_addr = 12'h3A0; step();
    req_valid = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    vectors++;
    if ({busy, iss_valid, batch_count} !== {2'b10, 3'd2}) begin
      errors++; $display("FAIL flush_sort: got busy=%b v=%b cnt=%0d want 1 0 2",
                         busy, iss_valid, batch_count);
    end
    step();
    vectors++;
    if ({iss_valid, iss_addr, iss_last} !== {1'b1, 12'h3A0, 1'b0}) begin
      errors++; $display("FAIL flush_issue0: got v=%b a=%h l=%b want 1 3a0 0", iss_valid, iss_addr, iss_last);
    end
    step();
    vectors++;
    if ({iss_valid, iss_addr, iss_last} !== {1'b1, 12'h000, 1'b1}) begin
      errors++; $display("FAIL flush_issue1: got v=%b a=%h l=%b want 1 000 1", iss_valid, iss_addr, iss_last);
    end
    step();
    vectors++;
    if ({iss_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL flush_no_padding: got v=%b busy=%b want 0 0", iss_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] in_v [4] = '{12'h010, 12'h020, 12'h030, 12'h040};
    logic [11:0] exp_v[4] = '{12'h040, 12'h030, 12'h020, 12'h010};
    iss_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = in_v[i]; step();
    end
    req_valid = 1'b1; req_addr = 12'h777;
    vectors++;
    if ({busy, req_ready} !== 2'b10) begin
      errors++; $display("FAIL bp_sort_ready: got busy=%b rdy=%b want 1 0", busy, req_ready);
    end
    step();
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({iss_valid, iss_addr, iss_last, req_ready, batch_count} !==
          {1'b1, 12'h040, 1'b0, 1'b0, 3'd4}) begin
        errors++; $display("FAIL bp_stall%0d: got v=%b a=%h l=%b rdy=%b cnt=%0d want 1 040 0 0 4",
                           i, iss_valid, iss_addr, iss_last, req_ready, batch_count);
      end
      step();
    end
    req_valid = 1'b0;
    iss_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({iss_valid, iss_addr, iss_last} !== {1'b1, exp_v[i], (i == 3)}) begin
        errors++; $display("FAIL bp_issue%0d: got v=%b a=%h l=%b want 1 %h %b",
                           i, iss_valid, iss_addr, iss_last, exp_v[i], (i == 3));
      end
      step();
    end
  endtask

  task automatic test_simultaneous_close();
    logic [11:0] in_v [4] = '{12'h300, 12'h100, 12'h200, 12'h250};
    logic [11:0] exp_v[4] = '{12'h300, 12'h250, 12'h200, 12'h100};
    iss_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = in_v[i]; flush = (i == 3); step();
    end
    req_valid = 1'b0; flush = 1'b0;
    vectors++;
    if ({busy, batch_count} !== {1'b1, 3'd4}) begin
      errors++; $display("FAIL simul_sort: got busy=%b cnt=%0d want 1 4", busy, batch_count);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({iss_valid, iss_addr, iss_last} !== {1'b1, exp_v[i], (i == 3)}) begin
        errors++; $display("FAIL simul_issue%0d: got v=%b a=%h l=%b want 1 %h %b",
                           i, iss_valid, iss_addr, iss_last, exp_v[i], (i == 3));
      end
      step();
    end
    // Timeout and accept in cycle 15 of a batch started at cycle 0.
    req_valid = 1'b1; req_addr = 12'h0AA; step();
    req_valid = 1'b0; repeat (14) step();
    req_valid = 1'b1; req_addr = 12'h0BB; step();
    req_valid = 1'b0;
    vectors++;
    if ({busy, iss_valid, batch_count} !== {2'b10, 3'd2}) begin
      errors++; $display("FAIL to_accept_sort: got busy=%b v=%b cnt=%0d want 1 0 2",
                         busy, iss_valid, batch_count);
    end
    step();
    vectors++;
    if ({iss_valid, iss_addr, iss_last} !== {1'b1, 12'h0BB, 1'b0}) begin
      errors++; $display("FAIL to_accept_issue0: got v=%b a=%h l=%b want 1 0bb 0", iss_valid, iss_addr, iss_last);
    end
    step();
    vectors++;
    if ({iss_valid, iss_addr, iss_last} !== {1'b1, 12'h0AA, 1'b1}) begin
      errors++; $display("FAIL to_accept_issue1: got v=%b a=%h l=%b want 1 0aa 1", iss_valid, iss_addr, iss_last);
    end
    step();
  endtask

  task automatic test_reset_mid_issue();
    logic [11:0] in_v[4] = '{12'h111, 12'h444, 12'h222, 12'h333};
    iss_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = in_v[i]; step();
    end
    req_valid = 1'b0;
    step();
    vectors++;
    if ({iss_valid, iss_addr} !== {1'b1, 12'h444}) begin
      errors++; $display("FAIL rmid_issue0: got v=%b a=%h want 1 444", iss_valid, iss_addr);
    end
    step();
    vectors++;
    if ({iss_valid, iss_addr} !== {1'b1, 12'h333}) begin
      errors++; $display("FAIL rmid_issue1: got v=%b a=%h want 1 333", iss_valid, iss_addr);
    end
    step();
    rst = 1'b1;
    step();
    vectors++;
    if ({iss_valid, busy, req_ready, batch_count} !== {3'b000, 3'd0}) begin
      errors++; $display("FAIL rmid_cleared: got v=%b busy=%b rdy=%b cnt=%0d want 0 0 0 0",
                         iss_valid, busy, req_ready, batch_count);
    end
    rst = 1'b0;
    req_valid = 1'b1; req_addr = 12'h00F; flush = 1'b1; step();
    req_valid = 1'b0; flush = 1'b0;
    vectors++;
    if ({busy, batch_count} !== {1'b1, 3'd1}) begin
      errors++; $display("FAIL rmid_new_sort: got busy=%b cnt=%0d want 1 1", busy, batch_count);
    end
    step();
    vectors++;
    if ({iss_valid, iss_addr, iss_last} !== {1'b1, 12'h00F, 1'b1}) begin
      errors++; $display("FAIL rmid_new_issue: got v=%b a=%h l=%b want 1 00f 1", iss_valid, iss_addr, iss_last);
    end
    step();
    vectors++;
    if ({iss_valid, busy, req_ready} !== 3'b001) begin
      errors++; $display("FAIL rmid_new_done: got v=%b busy=%b rdy=%b want 0 0 1", iss_valid, busy, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_full_batch();
    test_timeout();
    test_flush_zeros();
    test_backpressure();
    test_simultaneous_close();
    test_reset_mid_issue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
